// File: rtl/devil_req_arbiter_if.sv
// Requester-side valid/ready bus for devil_req_arbiter.
// Payload fields are flat packed vectors; slot k lives at [k*W +: W].
interface devil_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 44,
    parameter int DATA_W = 128
);
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*ADDR_W-1:0]   req_araddr;
    logic [N_REQ*4-1:0]        req_arsnoop;
    logic [N_REQ*4-1:0]        req_func;
    logic [N_REQ*4*DATA_W-1:0] req_cache_line;

    modport master (
        output req_valid, req_araddr, req_arsnoop, req_func, req_cache_line,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_araddr, req_arsnoop, req_func, req_cache_line,
        output req_ready
    );
endinterface

// File: rtl/devil_req_arbiter.sv
// N-way round-robin arbiter and payload latch in front of a single active_devil engine.
// A grant is held until the engine signals end or the programmable timeout expires.
module devil_req_arbiter #(
    parameter int N_REQ              = 4,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    localparam int IDX_W             = $clog2(N_REQ)
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    devil_req_arbiter_if.slave            req,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_timeout_reg,
    input  logic                          i_active_end,
    output logic                          o_trigger_active,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_araddr,
    output logic [3:0]                    o_arsnoop,
    output logic [3:0]                    o_func,
    output logic [4*C_ACE_DATA_WIDTH-1:0] o_cache_line,
    output logic [IDX_W-1:0]              o_grant_idx,
    output logic [N_REQ-1:0]              o_done,
    output logic                          o_timeout,
    output logic                          o_busy,
    output logic [2:0]                    o_fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_END = 3'd2,
        DONE     = 3'd3
    } state_t;

    state_t                        state;
    logic [IDX_W-1:0]              ptr;
    logic [C_S_AXI_DATA_WIDTH-1:0] cnt;

    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W:0]   slot;
    logic             tmo_hit;

    // Scan from the highest offset down so the last hit is the first requester at or after ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        slot      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            slot = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (slot >= (IDX_W + 1)'(N_REQ))
                slot = slot - (IDX_W + 1)'(N_REQ);
            if (req.req_valid[slot[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = slot[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req.req_ready = '0;
        if (state == IDLE && gnt_found)
            req.req_ready[gnt_idx] = 1'b1;
    end

    assign tmo_hit     = (i_timeout_reg != '0) &&
                         (cnt == i_timeout_reg - C_S_AXI_DATA_WIDTH'(1));
    assign o_busy      = (state != IDLE);
    assign o_fsm_state = state;

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            state            <= IDLE;
            ptr              <= '0;
            cnt              <= '0;
            o_trigger_active <= 1'b0;
            o_araddr         <= '0;
            o_arsnoop        <= '0;
            o_func           <= '0;
            o_cache_line     <= '0;
            o_grant_idx      <= '0;
            o_done           <= '0;
            o_timeout        <= 1'b0;
        end else begin
            o_trigger_active <= 1'b0;
            o_done           <= '0;
            o_timeout        <= 1'b0;
            case (state)
                IDLE: begin
                    if (|(req.req_valid & req.req_ready)) begin
                        o_araddr         <= req.req_araddr[gnt_idx*C_ACE_ADDR_WIDTH +: C_ACE_ADDR_WIDTH];
                        o_arsnoop        <= req.req_arsnoop[gnt_idx*4 +: 4];
                        o_func           <= req.req_func[gnt_idx*4 +: 4];
                        o_cache_line     <= req.req_cache_line[gnt_idx*4*C_ACE_DATA_WIDTH +: 4*C_ACE_DATA_WIDTH];
                        o_grant_idx      <= gnt_idx;
                        o_trigger_active <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    cnt <= cnt + C_S_AXI_DATA_WIDTH'(1);
                    // End takes priority over a timeout landing in the same cycle.
                    if (i_active_end) begin
                        o_done[o_grant_idx] <= 1'b1;
                        state               <= DONE;
                    end else if (tmo_hit) begin
                        o_done[o_grant_idx] <= 1'b1;
                        o_timeout           <= 1'b1;
                        state               <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= (o_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_devil_req_arbiter.sv
// Directed bench for devil_req_arbiter: stimulus queues expected trigger/done events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_devil_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 44;
    localparam int DW = 128;
    localparam int CW = 32;

    logic            ace_aclk = 1'b0;
    logic            ace_areset = 1'b1;
    logic [CW-1:0]   i_timeout_reg = '0;
    logic            i_active_end = 1'b0;
    logic            o_trigger_active;
    logic [AW-1:0]   o_araddr;
    logic [3:0]      o_arsnoop;
    logic [3:0]      o_func;
    logic [4*DW-1:0] o_cache_line;
    logic [1:0]      o_grant_idx;
    logic [N-1:0]    o_done;
    logic            o_timeout;
    logic            o_busy;
    logic [2:0]      o_fsm_state;

    always #5 ace_aclk = ~ace_aclk;

    devil_req_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    devil_req_arbiter #(
        .N_REQ(N), .C_ACE_ADDR_WIDTH(AW), .C_ACE_DATA_WIDTH(DW), .C_S_AXI_DATA_WIDTH(CW)
    ) dut (
        .ace_aclk(ace_aclk), .ace_areset(ace_areset), .req(bus.slave),
        .i_timeout_reg(i_timeout_reg), .i_active_end(i_active_end),
        .o_trigger_active(o_trigger_active), .o_araddr(o_araddr), .o_arsnoop(o_arsnoop),
        .o_func(o_func), .o_cache_line(o_cache_line), .o_grant_idx(o_grant_idx),
        .o_done(o_done), .o_timeout(o_timeout), .o_busy(o_busy), .o_fsm_state(o_fsm_state)
    );

    typedef struct { logic [1:0] idx; logic [AW-1:0] addr; logic [3:0] func; } trig_t;
    typedef struct { logic [N-1:0] mask; logic to; logic [AW-1:0] addr; int at; } done_t;

    trig_t tq[$];
    done_t dq[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    always @(posedge ace_aclk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge ace_aclk) begin
        trig_t te;
        done_t de;
        if (!ace_areset) begin
            if (o_trigger_active) begin
                if (tq.size() == 0) chk("unexpected_trigger", 64'(tq.size()), 64'd1);
                else begin
                    te = tq.pop_front();
                    chk("trig_grant_idx", 64'(o_grant_idx), 64'(te.idx));
                    chk("trig_araddr", 64'(o_araddr), 64'(te.addr));
                    chk("trig_func", 64'(o_func), 64'(te.func));
                    chk("trig_arsnoop", 64'(o_arsnoop), 64'(te.func ^ 4'h5));
                end
            end
            if (o_done != '0) begin
                if (dq.size() == 0) chk("unexpected_done", 64'(o_done), 64'd0);
                else begin
                    de = dq.pop_front();
                    chk("done_mask", 64'(o_done), 64'(de.mask));
                    chk("done_timeout", 64'(o_timeout), 64'(de.to));
                    chk("done_araddr", 64'(o_araddr), 64'(de.addr));
                    if (de.at >= 0) chk("done_cycle", 64'(cyc), 64'(de.at));
                end
            end else if (o_timeout) begin
                chk("timeout_without_done", 64'(o_done), 64'd1);
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge ace_aclk);
        #1;
    endtask

    task automatic set_req(int k, logic v, logic [AW-1:0] a, logic [3:0] f);
        bus.req_valid[k]              = v;
        bus.req_araddr[k*AW +: AW]    = a;
        bus.req_arsnoop[k*4 +: 4]     = f ^ 4'h5;
        bus.req_func[k*4 +: 4]        = f;
        bus.req_cache_line[k*4*DW +: 4*DW] = {4*DW/4{4'(k)}};
    endtask

    task automatic push_trig(logic [1:0] idx, logic [AW-1:0] a, logic [3:0] f);
        trig_t t;
        t.idx = idx; t.addr = a; t.func = f;
        tq.push_back(t);
    endtask

    task automatic push_done(logic [N-1:0] m, logic to, logic [AW-1:0] a, int at);
        done_t d;
        d.mask = m; d.to = to; d.addr = a; d.at = at;
        dq.push_back(d);
    endtask

    task automatic wait_trigger(output int tcyc);
        logic got;
        got  = 1'b0;
        tcyc = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge ace_aclk);
            if (o_trigger_active) begin
                got  = 1'b1;
                tcyc = cyc;
            end
        end
        chk("trigger_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge ace_aclk);
            if (!o_busy) got = 1'b1;
        end
        chk("idle_reached", 64'(got), 64'd1);
    endtask

    // End pulse n cycles from now; done is expected in the following cycle.
    task automatic pulse_end(int n, logic [N-1:0] m, logic [AW-1:0] a);
        tick(n);
        i_active_end = 1'b1;
        push_done(m, 1'b0, a, cyc + 1);
        tick(1);
        i_active_end = 1'b0;
    endtask

    initial begin
        int t;
        bus.req_valid = '0;
        bus.req_araddr = '0;
        bus.req_arsnoop = '0;
        bus.req_func = '0;
        bus.req_cache_line = '0;

        // Reset state
        repeat (3) @(posedge ace_aclk);
        @(negedge ace_aclk);
        chk("rst_state", 64'(o_fsm_state), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_trigger", 64'(o_trigger_active), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_araddr", 64'(o_araddr), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        tick(1);
        ace_areset = 1'b0;
        tick(1);

        // Round-robin with all requesters held valid: 0,1,2,3,0
        for (int k = 0; k < N; k++) set_req(k, 1'b1, AW'(32'h100 * (k + 1)), 4'(k));
        for (int n = 0; n < 5; n++) push_trig(2'(n % 4), AW'(32'h100 * ((n % 4) + 1)), 4'(n % 4));
        for (int n = 0; n < 5; n++) begin
            wait_trigger(t);
            if (n == 4) bus.req_valid = '0;
            pulse_end(2, N'(1) << (n % 4), AW'(32'h100 * ((n % 4) + 1)));
        end
        wait_idle();

        // Single request, ready in the same cycle, payload may change after acceptance
        tick(1);
        set_req(2, 1'b1, 44'h1000, 4'hA);
        push_trig(2'd2, 44'h1000, 4'hA);
        @(negedge ace_aclk);
        chk("single_ready", 64'(bus.req_ready), 64'b0100);
        tick(1);
        set_req(2, 1'b0, 44'hDEAD, 4'h0);
        wait_trigger(t);
        pulse_end(5, 4'b0100, 44'h1000);
        wait_idle();

        // Payload latch survives requester changes until the next grant
        tick(1);
        set_req(1, 1'b1, 44'hAAAA, 4'h3);
        push_trig(2'd1, 44'hAAAA, 4'h3);
        tick(1);
        set_req(1, 1'b0, 44'hBBBB, 4'h4);
        wait_trigger(t);
        tick(3);
        chk("latch_hold_wait", 64'(o_araddr), 64'hAAAA);
        pulse_end(1, 4'b0010, 44'hAAAA);
        wait_idle();
        chk("latch_hold_idle", 64'(o_araddr), 64'hAAAA);
        chk("grant_idx_idle", 64'(o_grant_idx), 64'd1);
        tick(1);
        set_req(1, 1'b1, 44'hBBBB, 4'h4);
        push_trig(2'd1, 44'hBBBB, 4'h4);
        tick(1);
        bus.req_valid[1] = 1'b0;
        wait_trigger(t);
        pulse_end(1, 4'b0010, 44'hBBBB);
        wait_idle();

        // Timeout = 10, no end: done 10 cycles after WAIT_END entry (trigger cycle + 1)
        i_timeout_reg = 32'd10;
        tick(1);
        set_req(1, 1'b1, 44'h2000, 4'h5);
        push_trig(2'd1, 44'h2000, 4'h5);
        tick(1);
        bus.req_valid[1] = 1'b0;
        wait_trigger(t);
        push_done(4'b0010, 1'b1, 44'h2000, t + 11);
        wait_idle();

        // Tie: end arrives in the cycle the counter reaches 9
        tick(1);
        set_req(0, 1'b1, 44'h3000, 4'h6);
        push_trig(2'd0, 44'h3000, 4'h6);
        tick(1);
        bus.req_valid[0] = 1'b0;
        wait_trigger(t);
        pulse_end(10, 4'b0001, 44'h3000);
        wait_idle();

        // Timeout disabled: grant is held indefinitely
        i_timeout_reg = '0;
        tick(1);
        set_req(3, 1'b1, 44'h4000, 4'h7);
        push_trig(2'd3, 44'h4000, 4'h7);
        tick(1);
        bus.req_valid[3] = 1'b0;
        wait_trigger(t);
        tick(40);
        chk("no_timeout_busy", 64'(o_busy), 64'd1);
        chk("no_timeout_state", 64'(o_fsm_state), 64'd2);
        pulse_end(1, 4'b1000, 44'h4000);
        wait_idle();

        // Reset mid-WAIT_END: no done, pointer back to 0
        tick(1);
        set_req(2, 1'b1, 44'h5000, 4'h8);
        push_trig(2'd2, 44'h5000, 4'h8);
        tick(1);
        bus.req_valid[2] = 1'b0;
        wait_trigger(t);
        tick(3);
        ace_areset = 1'b1;
        tick(1);
        ace_areset = 1'b0;
        @(negedge ace_aclk);
        chk("midrst_state", 64'(o_fsm_state), 64'd0);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_araddr", 64'(o_araddr), 64'd0);
        chk("midrst_grant", 64'(o_grant_idx), 64'd0);
        tick(10);
        set_req(0, 1'b1, 44'h6000, 4'h9);
        set_req(3, 1'b1, 44'h7000, 4'h1);
        push_trig(2'd0, 44'h6000, 4'h9);
        wait_trigger(t);
        bus.req_valid[0] = 1'b0;
        push_trig(2'd3, 44'h7000, 4'h1);
        pulse_end(1, 4'b0001, 44'h6000);
        wait_trigger(t);
        bus.req_valid[3] = 1'b0;
        pulse_end(1, 4'b1000, 44'h7000);
        wait_idle();

        tick(5);
        chk("trig_queue_drained", 64'(tq.size()), 64'd0);
        chk("done_queue_drained", 64'(dq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
